// File: rtl/fb_pkg.sv
// Shared types and parameter derivations for the framebuffer rectangle-fill engine.
package fb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        FILL  = 3'd2,
        RD    = 3'd3,
        WR    = 3'd4,
        DONE  = 3'd5
    } fb_rect_state_t;

    function automatic int unsigned pixel_bytes(input int unsigned pixel_bits);
        return (pixel_bits - 32'd1) / 32'd8 + 32'd1;
    endfunction

    // log2 of the pixel size in bytes (pixel size is 1, 2 or 4 bytes)
    function automatic int unsigned pixel_shift(input int unsigned pbytes);
        int unsigned sh;
        case (pbytes)
            32'd4:   sh = 32'd2;
            32'd2:   sh = 32'd1;
            default: sh = 32'd0;
        endcase
        return sh;
    endfunction

    function automatic int unsigned addr_width(input int unsigned res_x,
                                               input int unsigned res_y,
                                               input int unsigned pixel_bits);
        return $clog2(res_x * res_y * pixel_bytes(pixel_bits));
    endfunction

    // Color already zero-extended to 32 bits; copy it into every pixel slot of the word.
    function automatic logic [31:0] replicate_color(input logic [31:0] color,
                                                    input int unsigned pbytes);
        logic [31:0] rep;
        case (pbytes)
            32'd1:   rep = {4{color[7:0]}};
            32'd2:   rep = {2{color[15:0]}};
            default: rep = color;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/fb_word_strobe.sv
// Byte-lane strobe and span end for one packed 32-bit write starting at pixel x.
module fb_word_strobe
    import fb_pkg::*;
#(
    parameter int XW          = 9,
    parameter int PIXEL_BYTES = 1
) (
    input  logic [XW-1:0] x,
    input  logic [XW-1:0] x_end,
    input  logic [1:0]    lane,
    output logic [3:0]    strobe,
    output logic [XW-1:0] next_x
);

    localparam int PB_SHIFT = pixel_shift(PIXEL_BYTES);

    logic [2:0]  lane_ext_s;
    logic [2:0]  room_s;
    logic [XW:0] boundary_s;
    logic [2:0]  px_s;
    logic [2:0]  bytes_s;

    // Span ends at the next word boundary or the clipped row end, whichever is first.
    always_comb begin
        lane_ext_s = {1'b0, lane};
        room_s     = (3'd4 - lane_ext_s) >> PB_SHIFT;
        boundary_s = {1'b0, x} + (XW+1)'(room_s);
        if (boundary_s < {1'b0, x_end}) begin
            next_x = boundary_s[XW-1:0];
        end else begin
            next_x = x_end;
        end
        px_s    = 3'(next_x - x);
        bytes_s = px_s << PB_SHIFT;
        strobe  = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) >= lane_ext_s) && (3'(i) < (lane_ext_s + bytes_s))) begin
                strobe[i] = 1'b1;
            end else begin
                strobe[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill write engine for framebuffer port_b; clips to the screen and packs pixels per word.
// Optional read-modify-write XOR mode is enabled by defining FB_RECT_FILL_XOR_EN.
module fb_rect_fill
    import fb_pkg::*;
#(
    parameter int  RESOLUTION_X = 400,
    parameter int  RESOLUTION_Y = 300,
    parameter int  PIXEL_BITS   = 8,
    localparam int XW = $clog2(RESOLUTION_X + 1),
    localparam int YW = $clog2(RESOLUTION_Y + 1),
    localparam int AW = addr_width(RESOLUTION_X, RESOLUTION_Y, PIXEL_BITS)
) (
    input  logic                  dp_clk,
    input  logic                  dp_reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [XW-1:0]         cmd_x0,
    input  logic [YW-1:0]         cmd_y0,
    input  logic [XW-1:0]         cmd_width,
    input  logic [YW-1:0]         cmd_height,
    input  logic [PIXEL_BITS-1:0] cmd_color,
    input  logic                  cmd_xor,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         port_b_address,
    output logic [31:0]           port_b_wr_data,
    output logic [3:0]            port_b_wr_en,
    output logic                  port_b_rd_en,
    input  logic [31:0]           port_b_rd_data
);

    localparam int PIXEL_BYTES = pixel_bytes(PIXEL_BITS);
    localparam int PB_SHIFT    = pixel_shift(PIXEL_BYTES);
    localparam int BW          = AW + 1;
    localparam logic [XW:0]   RES_X_EXT = (XW+1)'(RESOLUTION_X);
    localparam logic [YW:0]   RES_Y_EXT = (YW+1)'(RESOLUTION_Y);
    localparam logic [BW-1:0] PITCH     = BW'(RESOLUTION_X * PIXEL_BYTES);

    fb_rect_state_t state_r, state_nxt;

    logic [XW-1:0]         x0_r, width_r, x_end_r, cur_x_r;
    logic [YW-1:0]         y0_r, height_r, y_end_r, cur_y_r;
    logic [PIXEL_BITS-1:0] color_r;
    logic [BW-1:0]         row_base_r;
    logic [3:0]            strobe_r;
    logic [AW-1:0]         addr_r, addr_nxt;
    logic [3:0]            wr_en_r, wr_en_nxt;
    logic                  rd_en_r, rd_en_nxt;
    logic                  done_r, done_nxt;
    logic [31:0]           wr_data_r;

    logic [XW:0]   x_sum_s;
    logic [YW:0]   y_sum_s;
    logic [XW-1:0] x_end_s;
    logic [YW-1:0] y_end_s;
    logic          empty_s;
    logic [BW-1:0] setup_base_s;

    logic [XW-1:0] src_x_s, src_x_end_s, next_x_s, adv_x_s;
    logic [YW-1:0] src_y_s, adv_y_s;
    logic [BW-1:0] src_base_s, adv_base_s;
    logic [AW-1:0] byte_addr_s;
    logic [3:0]    strobe_s;
    logic          row_done_s;
    logic          more_s;
    logic          issue_s;
    logic          xor_mode_s;

`ifdef FB_RECT_FILL_XOR_EN
    logic xor_r;

    // Capture the XOR flag together with the rest of the command.
    always_ff @(posedge dp_clk or negedge dp_reset_n) begin
        if (!dp_reset_n) begin
            xor_r <= 1'b0;
        end else if ((state_r == IDLE) && cmd_valid) begin
            xor_r <= cmd_xor;
        end
    end

    assign xor_mode_s     = xor_r;
    assign port_b_wr_data = (state_r == WR) ? (port_b_rd_data ^ wr_data_r) : wr_data_r;
`else
    logic unused_s;

    assign unused_s       = ^{cmd_xor, port_b_rd_data};
    assign xor_mode_s     = 1'b0;
    assign port_b_wr_data = wr_data_r;
`endif

    // Clip the captured command to the screen; row_base of the first row is the only multiply.
    always_comb begin
        x_sum_s = {1'b0, x0_r} + {1'b0, width_r};
        y_sum_s = {1'b0, y0_r} + {1'b0, height_r};
        if (x_sum_s > RES_X_EXT) begin
            x_end_s = RES_X_EXT[XW-1:0];
        end else begin
            x_end_s = x_sum_s[XW-1:0];
        end
        if (y_sum_s > RES_Y_EXT) begin
            y_end_s = RES_Y_EXT[YW-1:0];
        end else begin
            y_end_s = y_sum_s[YW-1:0];
        end
        empty_s = (width_r == {XW{1'b0}}) || (height_r == {YW{1'b0}}) ||
                  ({1'b0, x0_r} >= RES_X_EXT) || ({1'b0, y0_r} >= RES_Y_EXT);
        setup_base_s = BW'(y0_r) * PITCH;
    end

    // The first word comes straight from the setup results, later words from the walk registers.
    always_comb begin
        if (state_r == SETUP) begin
            src_x_s     = x0_r;
            src_y_s     = y0_r;
            src_base_s  = setup_base_s;
            src_x_end_s = x_end_s;
        end else begin
            src_x_s     = cur_x_r;
            src_y_s     = cur_y_r;
            src_base_s  = row_base_r;
            src_x_end_s = x_end_r;
        end
        byte_addr_s = AW'(src_base_s + (BW'(src_x_s) << PB_SHIFT));
    end

    fb_word_strobe #(
        .XW          (XW),
        .PIXEL_BYTES (PIXEL_BYTES)
    ) u_word_strobe (
        .x      (src_x_s),
        .x_end  (src_x_end_s),
        .lane   (byte_addr_s[1:0]),
        .strobe (strobe_s),
        .next_x (next_x_s)
    );

    // Walk position after the word being issued; wrapping the row steps down one pitch.
    always_comb begin
        row_done_s = (next_x_s == src_x_end_s);
        if (row_done_s) begin
            adv_x_s    = x0_r;
            adv_y_s    = src_y_s + YW'(1);
            adv_base_s = src_base_s + PITCH;
        end else begin
            adv_x_s    = next_x_s;
            adv_y_s    = src_y_s;
            adv_base_s = src_base_s;
        end
        more_s = (cur_y_r != y_end_r);
    end

    // State register.
    always_ff @(posedge dp_clk or negedge dp_reset_n) begin
        if (!dp_reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) state_nxt = SETUP;
                else           state_nxt = IDLE;
            end
            SETUP: begin
                if (empty_s)         state_nxt = DONE;
                else if (xor_mode_s) state_nxt = RD;
                else                 state_nxt = FILL;
            end
            FILL: begin
                if (more_s) state_nxt = FILL;
                else        state_nxt = DONE;
            end
            RD:      state_nxt = WR;
            WR: begin
                if (more_s) state_nxt = RD;
                else        state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Port_b request for the next cycle: issue a word, or finish the write half of an XOR pair.
    always_comb begin
        addr_nxt  = addr_r;
        wr_en_nxt = 4'd0;
        rd_en_nxt = 1'b0;
        case (state_r)
            SETUP:    issue_s = !empty_s;
            FILL, WR: issue_s = more_s;
            default:  issue_s = 1'b0;
        endcase
        if (issue_s) begin
            addr_nxt = {byte_addr_s[AW-1:2], 2'b00};
            if (xor_mode_s) begin
                rd_en_nxt = 1'b1;
            end else begin
                wr_en_nxt = strobe_s;
            end
        end else if (state_r == RD) begin
            wr_en_nxt = strobe_r;
        end else begin
            wr_en_nxt = 4'd0;
        end
        done_nxt = (state_nxt == DONE);
    end

    // Registered port_b outputs and done pulse.
    always_ff @(posedge dp_clk or negedge dp_reset_n) begin
        if (!dp_reset_n) begin
            addr_r    <= {AW{1'b0}};
            wr_en_r   <= 4'd0;
            rd_en_r   <= 1'b0;
            done_r    <= 1'b0;
            wr_data_r <= 32'd0;
        end else begin
            addr_r  <= addr_nxt;
            wr_en_r <= wr_en_nxt;
            rd_en_r <= rd_en_nxt;
            done_r  <= done_nxt;
            if (state_r == SETUP) begin
                wr_data_r <= replicate_color(32'(color_r), PIXEL_BYTES);
            end
        end
    end

    // Command capture on the handshake edge.
    always_ff @(posedge dp_clk or negedge dp_reset_n) begin
        if (!dp_reset_n) begin
            x0_r     <= {XW{1'b0}};
            y0_r     <= {YW{1'b0}};
            width_r  <= {XW{1'b0}};
            height_r <= {YW{1'b0}};
            color_r  <= {PIXEL_BITS{1'b0}};
        end else if ((state_r == IDLE) && cmd_valid) begin
            x0_r     <= cmd_x0;
            y0_r     <= cmd_y0;
            width_r  <= cmd_width;
            height_r <= cmd_height;
            color_r  <= cmd_color;
        end
    end

    // Clipped bounds and walk position, advanced whenever a word is issued.
    always_ff @(posedge dp_clk or negedge dp_reset_n) begin
        if (!dp_reset_n) begin
            x_end_r    <= {XW{1'b0}};
            y_end_r    <= {YW{1'b0}};
            cur_x_r    <= {XW{1'b0}};
            cur_y_r    <= {YW{1'b0}};
            row_base_r <= {BW{1'b0}};
            strobe_r   <= 4'd0;
        end else begin
            if (state_r == SETUP) begin
                x_end_r <= x_end_s;
                y_end_r <= y_end_s;
            end
            if (issue_s) begin
                cur_x_r    <= adv_x_s;
                cur_y_r    <= adv_y_s;
                row_base_r <= adv_base_s;
                strobe_r   <= strobe_s;
            end
        end
    end

    assign cmd_ready      = (state_r == IDLE);
    assign busy           = (state_r != IDLE);
    assign done           = done_r;
    assign port_b_address = addr_r;
    assign port_b_wr_en   = wr_en_r;
    assign port_b_rd_en   = rd_en_r;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomized self-checking bench for fb_rect_fill (400x300, 8-bit) with a 1-cycle-read memory model.
module tb_fb_rect_fill;

    localparam int RX = 400;
    localparam int RY = 300;
`ifdef FB_RECT_FILL_XOR_EN
    localparam bit XOR_BUILD = 1'b1;
`else
    localparam bit XOR_BUILD = 1'b0;
`endif

    typedef struct {
        logic [16:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } op_t;

    logic        dp_clk = 1'b0;
    logic        dp_reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_x0 = 9'd0;
    logic [8:0]  cmd_y0 = 9'd0;
    logic [8:0]  cmd_width = 9'd0;
    logic [8:0]  cmd_height = 9'd0;
    logic [7:0]  cmd_color = 8'd0;
    logic        cmd_xor = 1'b0;
    logic        busy;
    logic        done;
    logic [16:0] port_b_address;
    logic [31:0] port_b_wr_data;
    logic [3:0]  port_b_wr_en;
    logic        port_b_rd_en;
    logic [31:0] port_b_rd_data;

    logic [31:0] mem [0:29999];
    bit          mem_ready;
    op_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    fb_rect_fill dut (
        .dp_clk         (dp_clk),
        .dp_reset_n     (dp_reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_x0         (cmd_x0),
        .cmd_y0         (cmd_y0),
        .cmd_width      (cmd_width),
        .cmd_height     (cmd_height),
        .cmd_color      (cmd_color),
        .cmd_xor        (cmd_xor),
        .busy           (busy),
        .done           (done),
        .port_b_address (port_b_address),
        .port_b_wr_data (port_b_wr_data),
        .port_b_wr_en   (port_b_wr_en),
        .port_b_rd_en   (port_b_rd_en),
        .port_b_rd_data (port_b_rd_data)
    );

    always #5 dp_clk = ~dp_clk;

    // Framebuffer memory: word 0 starts as 0F0F0F0F, reads return data one cycle later.
    always @(posedge dp_clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 30000; i++) mem[i] <= (i == 0) ? 32'h0F0F0F0F : $urandom;
            mem_ready <= 1'b1;
        end else begin
            if (port_b_rd_en) port_b_rd_data <= mem[port_b_address[16:2]];
            for (int l = 0; l < 4; l++)
                if (port_b_wr_en[l]) mem[port_b_address[16:2]][8*l +: 8] <= port_b_wr_data[8*l +: 8];
        end
    end

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: walk every pixel of the clipped rectangle and group pixels by word address.
    task automatic build_expected(input int x0, input int y0, input int w, input int h,
                                  input logic [7:0] color, input bit xm);
        int  xe, ye, ba;
        op_t o;
        bit  have;
        exp_q.delete();
        if (w == 0 || h == 0 || x0 >= RX || y0 >= RY) return;
        xe = (x0 + w > RX) ? RX : x0 + w;
        ye = (y0 + h > RY) ? RY : y0 + h;
        for (int y = y0; y < ye; y++) begin
            have = 1'b0;
            for (int x = x0; x < xe; x++) begin
                ba = y * RX + x;
                if (have && (17'(ba - ba % 4) != o.addr)) begin
                    exp_q.push_back(o);
                    have = 1'b0;
                end
                if (!have) begin
                    o.addr = 17'(ba - ba % 4);
                    o.strb = 4'd0;
                    o.data = xm ? (mem[ba / 4] ^ {4{color}}) : {4{color}};
                    have   = 1'b1;
                end
                o.strb[ba % 4] = 1'b1;
            end
            if (have) exp_q.push_back(o);
        end
    endtask

    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [7:0] color, input bit xr, input int abort_at);
        int  k, limit, n_wr, n_rd, last_k, done_k, exp_k;
        bit  xm, seen_done;
        xm = xr && XOR_BUILD;
        build_expected(x0, y0, w, h, color, xm);
        limit = 2 * exp_q.size() + 10;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge dp_clk);
            k++;
        end
        check("ready_before_cmd", cmd_ready, 1'b1);
        cmd_x0 = 9'(x0); cmd_y0 = 9'(y0); cmd_width = 9'(w); cmd_height = 9'(h);
        cmd_color = color; cmd_xor = xr; cmd_valid = 1'b1;
        @(posedge dp_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 9'($urandom); cmd_y0 = 9'($urandom); cmd_width = 9'($urandom);
        cmd_height = 9'($urandom); cmd_color = 8'($urandom); cmd_xor = 1'($urandom);
        n_wr = 0; n_rd = 0; last_k = 1; done_k = 0; seen_done = 1'b0;
        for (k = 1; k <= limit && !seen_done; k++) begin
            @(negedge dp_clk);
            if (abort_at != 0 && k == abort_at) begin
                check("busy_before_reset", busy, 1'b1);
                #2 dp_reset_n = 1'b0;
                #1;
                check("reset_mid_fill",
                      {busy, done, port_b_rd_en, port_b_wr_en, port_b_address, port_b_wr_data, cmd_ready},
                      {1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 32'd0, 1'b1});
                @(negedge dp_clk);
                dp_reset_n = 1'b1;
                @(negedge dp_clk);
                check("ready_after_reset", {cmd_ready, busy}, 2'b10);
                return;
            end
            if (k == 1) check("setup_busy", {busy, cmd_ready, port_b_wr_en}, {1'b1, 1'b0, 4'd0});
            if (port_b_rd_en) begin
                if (!xm || n_rd >= exp_q.size()) check("rd_unexpected", {16'(k), port_b_address}, 33'd0);
                else check("rd_op", {16'(k), port_b_address}, {16'(2 + 2 * n_rd), exp_q[n_rd].addr});
                n_rd++;
            end
            if (port_b_wr_en != 4'd0) begin
                exp_k = xm ? 3 + 2 * n_wr : 2 + n_wr;
                if (n_wr >= exp_q.size())
                    check("wr_unexpected", {16'(k), port_b_address, port_b_wr_en}, 37'd0);
                else
                    check("wr_op", {16'(k), port_b_address, port_b_wr_en, port_b_wr_data},
                          {16'(exp_k), exp_q[n_wr].addr, exp_q[n_wr].strb, exp_q[n_wr].data});
                last_k = k;
                n_wr++;
            end
            if (done) begin
                seen_done = 1'b1;
                done_k    = k;
            end
        end
        check("done_seen", seen_done, 1'b1);
        check("write_count", n_wr, exp_q.size());
        check("done_cycle", done_k, (exp_q.size() == 0) ? 2 : last_k + 1);
        @(negedge dp_clk);
        check("ready_after_done", {cmd_ready, done, busy}, 3'b100);
    endtask

    initial begin
        repeat (3) @(negedge dp_clk);
        check("reset_state",
              {cmd_ready, busy, done, port_b_rd_en, port_b_wr_en, port_b_address, port_b_wr_data},
              {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 17'd0, 32'd0});
        dp_reset_n = 1'b1;
        @(negedge dp_clk);
`ifdef FB_RECT_FILL_XOR_EN
        run_cmd(0, 0, 4, 1, 8'hFF, 1'b1, 0);
`endif
        run_cmd(0, 0, 4, 1, 8'hA5, 1'b0, 0);
        run_cmd(1, 2, 6, 1, 8'h3C, 1'b0, 0);
        run_cmd(398, 299, 10, 5, 8'h77, 1'b0, 0);
        run_cmd(5, 5, 0, 3, 8'h12, 1'b0, 0);
        run_cmd(400, 10, 5, 5, 8'h34, 1'b0, 0);
        run_cmd(10, 300, 5, 5, 8'h56, 1'b0, 0);
        run_cmd(7, 7, 9, 0, 8'h9A, 1'b1, 0);
        for (int i = 0; i < 40; i++) begin
            run_cmd($urandom_range(0, 410), $urandom_range(0, 305), $urandom_range(0, 24),
                    $urandom_range(0, 6), 8'($urandom), 1'($urandom), 0);
        end
        run_cmd(0, 0, 400, 300, 8'h5A, 1'b0, 0);
        run_cmd(0, 0, 400, 300, 8'hC3, 1'b0, 1000);
        run_cmd(3, 4, 7, 2, 8'h11, 1'b1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
